// File: rtl/gate_test_sequencer.sv
// Stimulus/check controller for an inverter block: drives an alternating bit,
// waits a settle window, and compares two parallel gate outputs against ~dut_in.
module gate_test_sequencer #(
  parameter int TEST_NUMBER = 5,
  parameter int SETTLE_CYC  = 1,
  parameter int ERR_W       = 4,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out_a,
  input  logic             dut_out_b,
  output logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] vec_idx
);

  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEST_NUMBER - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               dut_in_q, dut_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               exp_bit, ok_a, ok_b, mism;

  always_comb begin
    state_d   = state_q;
    dut_in_d  = dut_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    vec_idx_d = vec_idx_q;
    cnt_d     = cnt_q;
    exp_bit   = ~dut_in_q;
    ok_a      = (dut_out_a == exp_bit);
    ok_b      = (dut_out_b == exp_bit);
    // Default to mismatch so an unknown comparison result counts as a failure.
    mism      = 1'b1;
    if (ok_a && ok_b) mism = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_DRIVE;
          busy_d    = 1'b1;
          vec_idx_d = '0;
          err_d     = '0;
          pass_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        dut_in_d = vec_idx_q[0];
        cnt_d    = CNT_W'(SETTLE_CYC);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mism && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_W'(1);
        if (vec_idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_idx_d = vec_idx_q + IDX_W'(1);
          state_d   = S_DRIVE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dut_in_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      vec_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dut_in_q  <= dut_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      vec_idx_q <= vec_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized bench: a reference model predicts per-cycle outputs from the run
// timeline (vector = cycle / (2+SETTLE)) and the set of faulty vectors.
module tb_gate_test_sequencer;
  localparam int TN = 5, S = 1, P = 2 + S, NDONE = TN * P + 1, ERRMAX = 15;
  localparam int TN2 = 20;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic       out_a, out_b, din, busy, done, pass;
  logic [3:0] err;
  logic [7:0] vidx;
  logic       din2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [7:0] vidx2;

  int n_cmp = 0, n_err = 0;
  int mode_a = 0, mode_b = 0;   // 0 ideal, 1 stuck-0, 2 buffer (always wrong), 3 random per vector
  bit bad_a[8], bad_b[8];
  bit last_din = 1'b0;

  always #5 clk = ~clk;

  function automatic logic drv(input int mode, input bit flag, input logic d);
    case (mode)
      1:       return 1'b0;
      2:       return d;
      3:       return flag ? d : ~d;
      default: return ~d;
    endcase
  endfunction

  function automatic bit vec_bad(input int mode, input bit flag, input int v);
    bit d = bit'(v % 2);
    case (mode)
      1:       return d == 1'b0;
      2:       return 1'b1;
      3:       return flag;
      default: return 1'b0;
    endcase
  endfunction

  assign out_a = drv(mode_a, bad_a[vidx[2:0]], din);
  assign out_b = drv(mode_b, bad_b[vidx[2:0]], din);

  gate_test_sequencer #(.TEST_NUMBER(TN), .SETTLE_CYC(S), .ERR_W(4), .IDX_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out_a(out_a), .dut_out_b(out_b),
    .dut_in(din), .busy(busy), .done(done), .pass(pass), .err_count(err), .vec_idx(vidx));

  gate_test_sequencer #(.TEST_NUMBER(TN2), .SETTLE_CYC(S), .ERR_W(4), .IDX_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_out_a(din2), .dut_out_b(din2),
    .dut_in(din2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_idx(vidx2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".din"}, 32'(din), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".vidx"}, 32'(vidx), 0);
  endtask

  // One run from an IDLE negedge. keep: leave start high at the end.
  // repulse: cycle at which start is pulsed mid-run. abort_at: cycle to assert reset.
  task automatic run(input string tag, input bit keep, input int repulse, input int abort_at);
    int cum[TN+1];
    int v, off, k, e_err, e_vi;
    bit e_din;
    cum[0] = 0;
    for (int i = 0; i < TN; i++)
      cum[i+1] = cum[i] + int'(vec_bad(mode_a, bad_a[i], i) | vec_bad(mode_b, bad_b[i], i));
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= NDONE + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !keep) start = 1'b0;
      if (repulse > 0) begin
        if (c == repulse) start = 1'b1;
        else if (c == repulse + 1) start = 1'b0;
      end
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero({tag, ".abort"});
        last_din = 1'b0;
        return;
      end
      v   = (c - 1) / P;
      off = (c - 1) % P;
      if (c > TN * P) begin
        e_vi  = TN - 1;
        e_din = bit'((TN - 1) % 2);
      end else begin
        e_vi  = v;
        e_din = (off != 0) ? bit'(v % 2) : (v == 0) ? last_din : bit'((v - 1) % 2);
      end
      k     = (v > TN) ? TN : v;
      e_err = (cum[k] > ERRMAX) ? ERRMAX : cum[k];
      chk({tag, ".vidx"}, 32'(vidx), 32'(e_vi));
      chk({tag, ".din"},  32'(din),  32'(e_din));
      chk({tag, ".err"},  32'(err),  32'(e_err));
      chk({tag, ".busy"}, 32'(busy), 32'(c <= NDONE));
      chk({tag, ".done"}, 32'(done), 32'(c == NDONE));
      chk({tag, ".pass"}, 32'(pass), (c >= NDONE) ? 32'(cum[TN] == 0) : 0);
    end
    last_din = bit'((TN - 1) % 2);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 8; i++) begin bad_a[i] = 0; bad_b[i] = 0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    mode_a = 0; mode_b = 0; run("ideal", 0, 0, 0);
    mode_b = 1;             run("b_stuck0", 0, 0, 0);
    mode_b = 0;             run("repulse", 0, 5, 0);
    run("abort", 0, 0, 8);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst.done", 32'(done), 0);
      chk("post_rst.busy", 32'(busy), 0);
    end
    run("fresh", 0, 0, 0);
    mode_b = 1; run("b2b_fail", 1, 0, 0);
    mode_b = 0; run("b2b_pass", 0, 0, 0);

    mode_a = 3; mode_b = 3;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        bad_a[i] = ($urandom_range(0, 3) == 0);
        bad_b[i] = ($urandom_range(0, 3) == 0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run("random", 0, 0, 0);
    end
    mode_a = 0; mode_b = 0;

    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat.done_cycle", 32'(cyc), 32'(TN2 * P + 1));
    chk("sat.err", 32'(err2), ERRMAX);
    chk("sat.pass", 32'(pass2), 0);
    chk("sat.vidx", 32'(vidx2), TN2 - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
